rv_alu_arb: RTL and testbench
=============================

// Module: rv_alu_arb
// PURPOSE
//  Shares the single integer ALU (ALU control decoder plus ALU datapath) between NREQ requesters.
//  - Typical requesters: execute stage, address-gen, CSR unit.
//  - Round-robin arbitration; the granted request's op fields and operands are muxed onto the ALU.
//  - The ALU result is captured in a one-entry response register tagged with the requester ID.
//  - Backpressure from the consumer stalls new grants.
// PARAMETERS
//  NREQ  3   number of requesters (2..8)
//  XLEN  32  operand/result width
//  IDW   2   requester-ID width, >= clog2(NREQ)
// PORTS
//  clk_i          in   1          core clock
//  rst_i          in   1          synchronous, active-high reset
//  req_valid_i    in   NREQ       per-requester request valid
//  req_ready_o    out  NREQ       per-requester grant/accept (one-hot or zero)
//  req_alu_op_i   in   NREQ*2     alu_op per requester, packed [i*2+:2]
//  req_funct7_i   in   NREQ*7     funct7 per requester
//  req_funct3_i   in   NREQ*3     funct3 per requester
//  req_a_i        in   NREQ*XLEN  operand A per requester
//  req_b_i        in   NREQ*XLEN  operand B per requester
//  alu_op_o       out  2          to ALU control decoder
//  alu_funct7_o   out  7          to ALU control decoder
//  alu_funct3_o   out  3          to ALU control decoder
//  alu_a_o        out  XLEN       to ALU
//  alu_b_o        out  XLEN       to ALU
//  alu_sel_i      in   4          op select back from ALU control decoder (comb)
//  alu_result_i   in   XLEN       ALU result (comb, same cycle)
//  rsp_valid_o    out  1          response valid
//  rsp_ready_i    in   1          consumer accepts response
//  rsp_id_o       out  IDW        requester index of the response
//  rsp_data_o     out  XLEN       captured ALU result
//  rsp_err_o      out  1          op decoded as invalid (alu_sel_i==4'b1111)
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge):
//    - rsp_valid_o=0; rsp_id_o=0; rsp_data_o=0; rsp_err_o=0.
//    - RR pointer=0. Any in-flight response is dropped.
//  - slot_free = !rsp_valid_o || rsp_ready_i (comb).
//  - Grant:
//    - If slot_free and any req_valid_i, grant the first valid index scanning ptr, ptr+1, ... mod NREQ.
//    - req_ready_o is one-hot on the winner, comb, and is 0 while rst_i=1.
//    - No grant -> req_ready_o=0.
//  - Request transfer occurs on req_valid_i[i] && req_ready_o[i].
//    - The requester holds valid and payload stable until the transfer; dropping valid early is illegal.
//  - ALU drive: on a grant, alu_* = winner's fields; otherwise alu_* = 0 (alu_op 2'b00).
//  - Latency: 1 cycle. At the transfer edge:
//    - rsp_valid_o<=1; rsp_id_o<=winner.
//    - rsp_err_o<=(alu_sel_i==4'b1111).
//    - rsp_data_o<=err ? 0 : alu_result_i.
//    - ptr<=(winner+1) mod NREQ.
//  - Response: held stable while rsp_valid_o && !rsp_ready_i.
//    - Accept with no new transfer -> rsp_valid_o<=0; data/id/err keep their last values.
//  - Simultaneous accept + new transfer: the register is overwritten the same edge.
//    - Full throughput is 1 op/cycle.
//  - Stall: rsp_valid_o=1 && rsp_ready_i=0 -> no grants; ptr unchanged.
//  - Wrap-around: winner NREQ-1 -> ptr=0.
//  - An idle cycle (no valid requests) leaves ptr unchanged.
// STRUCTURE
//  - rv_alu_pkg holds the shared constants:
//    - ALU_SEL_AND=4'b0000, ALU_SEL_OR=4'b0001, ALU_SEL_ADD=4'b0010, ALU_SEL_SUB=4'b0110, ALU_SEL_INV=4'b1111.
//    - ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10.
//    - The ALU control decoder imports the same package.
//  - Sub-module rv_rr_arbiter #(N):
//    - Inputs: clk_i, rst_i, req[N], en (=slot_free).
//    - Outputs: gnt[N] one-hot, gnt_idx.
//    - Owns the ptr register. Top level = arbiter + payload muxes + response register.
// TESTING
//  - Reset:
//    - Assert rst_i 2 cycles with req_valid_i=3'b111 -> req_ready_o=0 during reset.
//    - After release, the first grant goes to idx 0.
//    - rsp_* all 0 at release.
//  - Single op:
//    - req0 alu_op=2'b10, f7=0, f3=0, A=5, B=7, ready_i=1.
//    - -> next cycle rsp_valid=1, id=0, data=12, err=0.
//  - Round-robin:
//    - req_valid_i=3'b111 held, rsp_ready_i=1 -> grant order 0,1,2,0,...
//    - One rsp per cycle; ids 0,1,2,0.
//  - Backpressure:
//    - Hold rsp_ready_i=0 for 3 cycles with rsp pending -> req_ready_o=0, rsp_* stable.
//    - Raise ready_i -> same-cycle new grant; next edge overwrites the response.
//  - Invalid op:
//    - req1 alu_op=2'b10, f7=7'b0100000, f3=3'b111 -> rsp id=1, err=1, data=0.
//  - Reset mid-op:
//    - rst_i in the cycle after a grant with rsp_ready_i=0 -> rsp_valid_o=0 next cycle.
//    - Next grant starts at idx 0.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: constants shared by the ALU-sharing arbiter and the ALU control decoder.
//   - ALU_SEL_*: 4-bit op select produced by the ALU control decoder.
//   - ALUOP_*:   2-bit alu_op class produced by the main instruction decoder.
//   - alu_ctrl_t: the op fields one requester presents to the decoder.
package rv_alu_pkg;

    localparam logic [3:0] ALU_SEL_AND = 4'b0000;
    localparam logic [3:0] ALU_SEL_OR  = 4'b0001;
    localparam logic [3:0] ALU_SEL_ADD = 4'b0010;
    localparam logic [3:0] ALU_SEL_SUB = 4'b0110;
    localparam logic [3:0] ALU_SEL_INV = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [6:0] funct7;
        logic [2:0] funct3;
    } alu_ctrl_t;

    // The decoder flags any op it cannot map with the all-ones select.
    function automatic logic is_inv_sel(input logic [3:0] sel);
        return sel == ALU_SEL_INV;
    endfunction

endpackage

// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: round-robin arbiter owning the priority pointer.
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0, no grant)
//   req[N]       : request vector
//   en           : grant enable (downstream slot can take a result)
//   gnt[N]       : one-hot grant, zero when disabled, in reset or idle
//   gnt_idx      : index of the granted requester (0 when no grant)
// The pointer moves to winner+1 (mod N) only when a grant is issued, so idle
// and stalled cycles keep the current priority order.
module rv_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // One extra bit so ptr+k (up to 2N-2) cannot overflow before the wrap.
    localparam int SW = IW + 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        if (en && !rst_i) begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, ptr_q} + SW'(k);
                if (cand >= SW'(N)) begin
                    cand = cand - SW'(N);
                end
                if (!found && req[cand[IW-1:0]]) begin
                    found                = 1'b1;
                    gnt[cand[IW-1:0]]    = 1'b1;
                    gnt_idx              = cand[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rv_alu_arb.sv
// rv_alu_arb: shares one integer ALU (control decoder + datapath) among NREQ
// requesters with round-robin arbitration and a one-entry response register.
//   req_*_i / req_ready_o : per-requester request channel, fields packed per index
//   alu_*_o               : winner's op fields and operands toward decoder/ALU
//   alu_sel_i/alu_result_i: combinational select and result coming back
//   rsp_*                 : registered response tagged with the requester index
//
// Handshakes: a request moves on req_valid_i[i] && req_ready_o[i]; the
// requester keeps valid and payload steady until then. A response moves on
// rsp_valid_o && rsp_ready_i; the register holds its contents while the
// consumer stalls, and can be refilled on the same edge it is drained, so
// back-to-back ops run at one per cycle.
module rv_alu_arb
    import rv_alu_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int IDW  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*2-1:0]    req_alu_op_i,
    input  logic [NREQ*7-1:0]    req_funct7_i,
    input  logic [NREQ*3-1:0]    req_funct3_i,
    input  logic [NREQ*XLEN-1:0] req_a_i,
    input  logic [NREQ*XLEN-1:0] req_b_i,
    output logic [1:0]           alu_op_o,
    output logic [6:0]           alu_funct7_o,
    output logic [2:0]           alu_funct3_o,
    output logic [XLEN-1:0]      alu_a_o,
    output logic [XLEN-1:0]      alu_b_o,
    input  logic [3:0]           alu_sel_i,
    input  logic [XLEN-1:0]      alu_result_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [XLEN-1:0]      rsp_data_o,
    output logic                 rsp_err_o
);

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            slot_free;
    logic            xfer;

    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    alu_ctrl_t       ctrl_mux;
    logic [XLEN-1:0] a_mux, b_mux;

    // The register can take a new result if empty or being drained this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready_i;

    rv_rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (req_valid_i),
        .en      (slot_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A grant only ever lands on a valid requester, so any grant is a transfer.
    assign xfer        = |gnt;
    assign req_ready_o = gnt;

    // One-hot AND-OR mux; with no grant the ALU sees all zeros (alu_op ADD).
    always_comb begin
        ctrl_mux = '0;
        a_mux    = '0;
        b_mux    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                ctrl_mux.alu_op = req_alu_op_i[i*2 +: 2];
                ctrl_mux.funct7 = req_funct7_i[i*7 +: 7];
                ctrl_mux.funct3 = req_funct3_i[i*3 +: 3];
                a_mux           = req_a_i[i*XLEN +: XLEN];
                b_mux           = req_b_i[i*XLEN +: XLEN];
            end
        end
    end

    assign alu_op_o     = ctrl_mux.alu_op;
    assign alu_funct7_o = ctrl_mux.funct7;
    assign alu_funct3_o = ctrl_mux.funct3;
    assign alu_a_o      = a_mux;
    assign alu_b_o      = b_mux;

    // Drained without refill clears only valid; id/data/err keep their values.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_err_d   = is_inv_sel(alu_sel_i);
            rsp_data_d  = is_inv_sel(alu_sel_i) ? '0 : alu_result_i;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_rv_alu_arb.sv
// tb_rv_alu_arb: directed bench for rv_alu_arb with a stand-in ALU decoder and
// datapath, a transaction-level reference model and a per-cycle compare.
module tb_rv_alu_arb;
    import rv_alu_pkg::*;

    localparam int N    = 3;
    localparam int XLEN = 32;
    localparam int IDW  = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      req_valid, req_ready;
    logic [N*2-1:0]    req_alu_op;
    logic [N*7-1:0]    req_f7;
    logic [N*3-1:0]    req_f3;
    logic [N*XLEN-1:0] req_a, req_b;
    logic [1:0]        alu_op;
    logic [6:0]        alu_f7;
    logic [2:0]        alu_f3;
    logic [XLEN-1:0]   alu_a, alu_b, alu_result;
    logic [3:0]        alu_sel;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [IDW-1:0]    rsp_id;
    logic [XLEN-1:0]   rsp_data;

    rv_alu_arb #(.NREQ(N), .XLEN(XLEN), .IDW(IDW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_alu_op_i (req_alu_op),
        .req_funct7_i (req_f7),
        .req_funct3_i (req_f3),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .alu_op_o     (alu_op),
        .alu_funct7_o (alu_f7),
        .alu_funct3_o (alu_f3),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_sel_i    (alu_sel),
        .alu_result_i (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err)
    );

    // ---------------- stand-in ALU decoder and datapath ----------------
    function automatic logic [3:0] dec_sel(input logic [1:0] op, input logic [6:0] f7,
                                           input logic [2:0] f3);
        case (op)
            ALUOP_ADD: return ALU_SEL_ADD;
            ALUOP_SUB: return ALU_SEL_SUB;
            ALUOP_RTYPE: begin
                if (f7 == 7'd0 && f3 == 3'd0) return ALU_SEL_ADD;
                if (f7 == 7'b0100000 && f3 == 3'd0) return ALU_SEL_SUB;
                if (f7 == 7'd0 && f3 == 3'b111) return ALU_SEL_AND;
                if (f7 == 7'd0 && f3 == 3'b110) return ALU_SEL_OR;
                return ALU_SEL_INV;
            end
            default: return ALU_SEL_INV;
        endcase
    endfunction

    // Garbage on an invalid select so the zeroing of rsp_data is observable.
    function automatic logic [XLEN-1:0] alu_exec(input logic [3:0] sel,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        case (sel)
            ALU_SEL_AND: return a & b;
            ALU_SEL_OR:  return a | b;
            ALU_SEL_ADD: return a + b;
            ALU_SEL_SUB: return a - b;
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_sel    = dec_sel(alu_op, alu_f7, alu_f3);
        alu_result = alu_exec(alu_sel, alu_a, alu_b);
    end

    // ---------------- scoreboard counters and check ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Holds the response register contents and whose turn it is.
    int              m_ptr   = 0;
    logic            m_valid = 1'b0;
    logic [IDW-1:0]  m_id    = '0;
    logic [XLEN-1:0] m_data  = '0;
    logic            m_err   = 1'b0;

    // Winner = valid requester at the smallest circular distance from m_ptr.
    function automatic int model_winner();
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N;
        if (rst || (m_valid && !rsp_ready)) return -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
                d = (i - m_ptr + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin : model_update
        int w;
        logic [3:0] s;
        w = model_winner();
        if (rst) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_id    = '0;
            m_data  = '0;
            m_err   = 1'b0;
        end else if (w >= 0) begin
            s       = dec_sel(req_alu_op[w*2 +: 2], req_f7[w*7 +: 7], req_f3[w*3 +: 3]);
            m_valid = 1'b1;
            m_id    = w[IDW-1:0];
            m_err   = (s == ALU_SEL_INV);
            m_data  = m_err ? '0 : alu_exec(s, req_a[w*XLEN +: XLEN], req_b[w*XLEN +: XLEN]);
            m_ptr   = (w + 1) % N;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        int w;
        logic [N-1:0] eg;
        w  = model_winner();
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("cmp_req_ready", 64'(req_ready), 64'(eg));
        chk("cmp_alu_op",  64'(alu_op), (w >= 0) ? 64'(req_alu_op[w*2 +: 2]) : 64'd0);
        chk("cmp_alu_f7",  64'(alu_f7), (w >= 0) ? 64'(req_f7[w*7 +: 7]) : 64'd0);
        chk("cmp_alu_f3",  64'(alu_f3), (w >= 0) ? 64'(req_f3[w*3 +: 3]) : 64'd0);
        chk("cmp_alu_a",   64'(alu_a), (w >= 0) ? 64'(req_a[w*XLEN +: XLEN]) : 64'd0);
        chk("cmp_alu_b",   64'(alu_b), (w >= 0) ? 64'(req_b[w*XLEN +: XLEN]) : 64'd0);
        chk("cmp_rsp_valid", 64'(rsp_valid), 64'(m_valid));
        chk("cmp_rsp_id",    64'(rsp_id), 64'(m_id));
        chk("cmp_rsp_data",  64'(rsp_data), 64'(m_data));
        chk("cmp_rsp_err",   64'(rsp_err), 64'(m_err));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b);
        req_alu_op[i*2 +: 2]  = op;
        req_f7[i*7 +: 7]      = f7;
        req_f3[i*3 +: 3]      = f3;
        req_a[i*XLEN +: XLEN] = a;
        req_b[i*XLEN +: XLEN] = b;
    endtask

    // Mixed-op table for the free-running phase.
    logic [1:0] op_t [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [6:0] f7_t [6] = '{7'd0, 7'd0, 7'b0100000, 7'd0, 7'd0, 7'd0};
    logic [2:0] f3_t [6] = '{3'd0, 3'd0, 3'd0, 3'b111, 3'b110, 3'd0};
    logic [23:0] rdy_pat = 24'b1011_1101_0111_1110_1101_1011;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int ids [4];
        logic [N-1:0] xfer;
        int k;

        // Reset held two edges with every requester asking.
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) set_req(i, ALUOP_ADD, 7'd0, 3'd0, 32'(100 * i + 1), 32'd10);
        @(negedge clk);
        chk("rst_req_ready_zero", 64'(req_ready), 64'd0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_first_grant_idx0", 64'(req_ready), 64'b001);
        chk("rel_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rel_rsp_id",    64'(rsp_id), 64'd0);
        chk("rel_rsp_data",  64'(rsp_data), 64'd0);
        chk("rel_rsp_err",   64'(rsp_err), 64'd0);

        // Round-robin with all requesters valid: 0,1,2,0 one per cycle.
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            ids[c] = int'(rsp_id);
            chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        end
        chk("rr_id0", 64'(ids[0]), 64'd0);
        chk("rr_id1", 64'(ids[1]), 64'd1);
        chk("rr_id2", 64'(ids[2]), 64'd2);
        chk("rr_id3", 64'(ids[3]), 64'd0);
        chk("rr_data_req0", 64'(rsp_data), 64'd11);

        // Drain, then a single R-type add from requester 0: 5 + 7.
        step();
        req_valid = 3'b000;
        step();
        set_req(0, ALUOP_RTYPE, 7'd0, 3'd0, 32'd5, 32'd7);
        req_valid = 3'b001;
        @(negedge clk);
        chk("single_grant", 64'(req_ready), 64'b001);
        step();
        // Backpressure: response pending, requester 1 waiting with 50 - 8.
        req_valid = 3'b010;
        set_req(1, ALUOP_SUB, 7'd0, 3'd0, 32'd50, 32'd8);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_id",    64'(rsp_id), 64'd0);
        chk("single_rsp_data",  64'(rsp_data), 64'd12);
        chk("single_rsp_err",   64'(rsp_err), 64'd0);
        for (int c = 0; c < 3; c++) begin
            if (c != 0) step();
            @(negedge clk);
            chk("bp_no_grant",  64'(req_ready), 64'd0);
            chk("bp_rsp_data",  64'(rsp_data), 64'd12);
            chk("bp_rsp_id",    64'(rsp_id), 64'd0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 64'(req_ready), 64'b010);
        step();
        req_valid = 3'b000;
        @(negedge clk);
        chk("bp_overwrite_id",   64'(rsp_id), 64'd1);
        chk("bp_overwrite_data", 64'(rsp_data), 64'd42);

        // Invalid R-type encoding from requester 1.
        step();
        set_req(1, ALUOP_RTYPE, 7'b0100000, 3'b111, 32'd9, 32'd3);
        req_valid = 3'b010;
        @(negedge clk);
        chk("inv_grant", 64'(req_ready), 64'b010);
        step();
        req_valid = 3'b000;
        @(negedge clk);
        chk("inv_rsp_id",   64'(rsp_id), 64'd1);
        chk("inv_rsp_err",  64'(rsp_err), 64'd1);
        chk("inv_rsp_data", 64'(rsp_data), 64'd0);

        // Reset in the cycle after a grant while the consumer stalls.
        step();
        set_req(2, ALUOP_ADD, 7'd0, 3'd0, 32'd3, 32'd4);
        req_valid = 3'b100;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("midrst_grant2", 64'(req_ready), 64'b100);
        step();
        rst       = 1'b1;
        req_valid = 3'b111;
        @(negedge clk);
        chk("midrst_ready_zero", 64'(req_ready), 64'd0);
        chk("midrst_rsp_pending", 64'(rsp_valid), 64'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_dropped", 64'(rsp_valid), 64'd0);
        chk("midrst_next_grant0", 64'(req_ready), 64'b001);
        step();
        req_valid = 3'b110;
        rsp_ready = 1'b1;

        // Mixed ops with irregular consumer backpressure; requesters refill
        // only after their previous request has transferred.
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            xfer = req_valid & req_ready;
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || xfer[i]) begin
                    if ((c + i) % 3 != 0) begin
                        k = (c + i) % 6;
                        set_req(i, op_t[k], f7_t[k], f3_t[k], 32'(c * 17 + i + 3), 32'(c * 3 + i + 1));
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = rdy_pat[c];
        end
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
